// File: rtl/uart_pkg.sv
// Shared UART definitions: receive state encoding, parity types, supported prescales.
package uart_pkg;

    localparam int unsigned PRESCALE_W = 6;

    // Parity type selector values
    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    // Oversampling ratios the receiver is built for
    localparam logic [PRESCALE_W-1:0] PRESCALE_8  = 6'd8;
    localparam logic [PRESCALE_W-1:0] PRESCALE_16 = 6'd16;
    localparam logic [PRESCALE_W-1:0] PRESCALE_32 = 6'd32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // True when the prescale is one of the supported oversampling ratios
    function automatic logic prescale_supported(input logic [PRESCALE_W-1:0] p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-point majority sampler around the middle of each bit period.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  sampled_bit_c
);

    logic [PRESCALE_W-1:0] mid;
    logic [2:0]            samples;

    assign mid = prescale >> 1;

    // Capture the line one edge before, at, and one edge after mid-bit
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samples <= '0;
        end else begin
            if (edge_cnt == mid - PRESCALE_W'(1)) samples[0] <= rx_in;
            if (edge_cnt == mid)                  samples[1] <= rx_in;
            if (edge_cnt == mid + PRESCALE_W'(1)) samples[2] <= rx_in;
        end
    end

    // Two-of-three vote; settles once the last sample has been taken
    assign sampled_bit_c = (samples[0] & samples[1]) |
                           (samples[0] & samples[2]) |
                           (samples[1] & samples[2]);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start detect, LSB-first deserialize, parity and stop checks.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH) + 1;

    rx_state_e             state;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  frame_err;

    logic                  sampled_bit_c;
    logic                  at_boundary_c;
    logic                  last_bit_c;
    logic                  exp_parity_c;

    uart_rx_sampler u_sampler (
        .CLK           (CLK),
        .RST           (RST),
        .rx_in         (RX_IN),
        .edge_cnt      (edge_cnt),
        .prescale      (prescale_q),
        .sampled_bit_c (sampled_bit_c)
    );

    assign at_boundary_c = (edge_cnt == prescale_q - PRESCALE_W'(1));
    assign last_bit_c    = (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1));
    assign exp_parity_c  = (^shift_reg) ^ par_typ_q;

    // Frame FSM with edge/bit counters, deserializer and registered strobes
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            prescale_q <= PRESCALE_16;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            frame_err  <= 1'b0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;

            if (state == IDLE) begin
                edge_cnt <= '0;
                bit_cnt  <= '0;
                if (!RX_IN) begin
                    // Detecting cycle is edge 0 of the start bit; frame config frozen here
                    edge_cnt   <= PRESCALE_W'(1);
                    par_en_q   <= PAR_EN;
                    par_typ_q  <= PAR_TYP;
                    prescale_q <= prescale_supported(Prescale) ? Prescale : PRESCALE_16;
                    state      <= START;
                end
            end else begin
                edge_cnt <= at_boundary_c ? '0 : edge_cnt + PRESCALE_W'(1);
                if (at_boundary_c) begin
                    case (state)
                        START: begin
                            // A start bit that votes high was a glitch
                            state <= sampled_bit_c ? IDLE : DATA;
                        end
                        DATA: begin
                            shift_reg <= {sampled_bit_c, shift_reg[DATA_WIDTH-1:1]};
                            bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
                            if (last_bit_c) begin
                                state <= par_en_q ? PARITY : STOP;
                            end
                        end
                        PARITY: begin
                            if (sampled_bit_c != exp_parity_c) begin
                                Par_Err   <= 1'b1;
                                frame_err <= 1'b1;
                            end
                            state <= STOP;
                        end
                        STOP: begin
                            if (!sampled_bit_c) begin
                                Stp_Err <= 1'b1;
                            end else if (!frame_err) begin
                                P_DATA     <= shift_reg;
                                Data_Valid <= 1'b1;
                            end
                            frame_err <= 1'b0;
                            state     <= IDLE;
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames against a frame-level model.
module tb_uart_rx;

    localparam int unsigned DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [5:0]    Prescale;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          Par_Err;
    logic          Stp_Err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Observed strobes (absolute cycle) and expected strobes from the model
    int            dv_q[$];
    int            pe_q[$];
    int            se_q[$];
    logic [DW-1:0] dvdata_q[$];
    int            exp_dv_q[$];
    int            exp_pe_q[$];
    int            exp_se_q[$];
    logic [DW-1:0] exp_data_q[$];
    logic [DW-1:0] exp_pdata;

    uart_rx #(.DATA_WIDTH(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Par_Err    (Par_Err),
        .Stp_Err    (Stp_Err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Record strobes mid-cycle; strobes of different kinds must never coincide with Data_Valid
    always @(negedge CLK) begin
        if (Data_Valid) begin
            dv_q.push_back(cyc);
            dvdata_q.push_back(P_DATA);
        end
        if (Par_Err) pe_q.push_back(cyc);
        if (Stp_Err) se_q.push_back(cyc);
        if (Data_Valid || Par_Err || Stp_Err) begin
            tests++;
            assert ((Data_Valid & (Par_Err | Stp_Err)) === 1'b0) else begin
                fails++;
                $error("FAIL strobe_overlap: observed dv=%b pe=%b se=%b expected dv alone", Data_Valid, Par_Err, Stp_Err);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Drive one frame cycle by cycle and enqueue the outcome predicted from the frame rules.
    // Called 1 time unit after a rising edge with the receiver idle; that cycle is cycle 0.
    task automatic send_frame(input logic [DW-1:0] data, input logic pen, input logic ptyp,
                              input logic par_flip, input logic stop, input int p,
                              input int glitch, input int abort);
        logic [15:0] fr;
        int          nb;
        int          t0;
        logic        pbit;
        logic        perr;
        pbit = 1'((($countones(data) + (ptyp ? 1 : 0)) % 2)) ^ par_flip;
        fr = '1;
        fr[0] = 1'b0;
        for (int i = 0; i < DW; i++) fr[1 + i] = data[i];
        nb = DW + 1;
        if (pen) begin
            fr[nb] = pbit;
            nb++;
        end
        fr[nb] = stop;
        nb++;
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        Prescale = 6'(p);
        t0 = cyc;
        for (int k = 0; k < nb * p; k++) begin
            if (k == abort) return;
            RX_IN = fr[k / p] ^ (k == glitch);
            if (k == 1) begin
                PAR_EN   = 1'($urandom);
                PAR_TYP  = 1'($urandom);
                Prescale = 6'(8 << $urandom_range(0, 2));
            end
            @(posedge CLK);
            #1;
        end
        RX_IN = 1'b1;
        perr = pen && par_flip;
        if (perr) exp_pe_q.push_back(t0 + (DW + 2) * p);
        if (!stop) begin
            exp_se_q.push_back(t0 + nb * p);
        end else if (!perr) begin
            exp_dv_q.push_back(t0 + nb * p);
            exp_data_q.push_back(data);
            exp_pdata = data;
        end
    endtask

    // Compare observed strobes against the model, then clear both sides
    task automatic verify(input string name);
        chk({name, "_dv_count"}, 32'(dv_q.size()), 32'(exp_dv_q.size()));
        for (int i = 0; i < dv_q.size() && i < exp_dv_q.size(); i++) begin
            chk({name, "_dv_cycle"}, 32'(dv_q[i]), 32'(exp_dv_q[i]));
            chk({name, "_dv_data"}, 32'(dvdata_q[i]), 32'(exp_data_q[i]));
        end
        chk({name, "_pe_count"}, 32'(pe_q.size()), 32'(exp_pe_q.size()));
        for (int i = 0; i < pe_q.size() && i < exp_pe_q.size(); i++)
            chk({name, "_pe_cycle"}, 32'(pe_q[i]), 32'(exp_pe_q[i]));
        chk({name, "_se_count"}, 32'(se_q.size()), 32'(exp_se_q.size()));
        for (int i = 0; i < se_q.size() && i < exp_se_q.size(); i++)
            chk({name, "_se_cycle"}, 32'(se_q[i]), 32'(exp_se_q[i]));
        chk({name, "_p_data"}, 32'(P_DATA), 32'(exp_pdata));
        dv_q.delete();
        pe_q.delete();
        se_q.delete();
        dvdata_q.delete();
        exp_dv_q.delete();
        exp_pe_q.delete();
        exp_se_q.delete();
        exp_data_q.delete();
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_p_data"}, 32'(P_DATA), 32'h0);
        chk({name, "_dv"}, 32'(Data_Valid), 32'h0);
        chk({name, "_pe"}, 32'(Par_Err), 32'h0);
        chk({name, "_se"}, 32'(Stp_Err), 32'h0);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          pen;
        logic          ptyp;
        logic          flip;
        logic          stop;
        int            p;
        int            g;

        RST       = 1'b0;
        RX_IN     = 1'b1;
        PAR_EN    = 1'b0;
        PAR_TYP   = uart_pkg::EVEN;
        Prescale  = 6'd8;
        exp_pdata = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk_outputs_zero("reset");
        RST = 1'b1;
        idle(3);

        // No parity, prescale 8
        send_frame(8'hA5, 1'b0, uart_pkg::EVEN, 1'b0, 1'b1, 8, -1, -1);
        idle(4);
        verify("p8_a5");

        // Even parity, correct parity bit
        send_frame(8'h3C, 1'b1, uart_pkg::EVEN, 1'b0, 1'b1, 16, -1, -1);
        idle(4);
        verify("even_3c");

        // Odd parity, wrong parity bit: Par_Err only, P_DATA held
        send_frame(8'h3C, 1'b1, uart_pkg::ODD, 1'b1, 1'b1, 16, -1, -1);
        idle(4);
        verify("odd_bad_3c");

        // Stop bit low, then a good frame
        send_frame(8'h81, 1'b0, uart_pkg::EVEN, 1'b0, 1'b0, 32, -1, -1);
        idle(4);
        verify("stop_err_81");
        send_frame(8'h7E, 1'b0, uart_pkg::EVEN, 1'b0, 1'b1, 32, -1, -1);
        idle(4);
        verify("recover_7e");

        // False start: line low for 4 cycles only
        PAR_EN   = 1'b0;
        Prescale = 6'd16;
        RX_IN    = 1'b0;
        repeat (4) begin
            @(posedge CLK);
            #1;
        end
        idle(20);
        verify("false_start");

        // Single-cycle glitch on the middle sample of data bit 3
        send_frame(8'h55, 1'b0, uart_pkg::EVEN, 1'b0, 1'b1, 16, 4 * 16 + 8, -1);
        idle(4);
        verify("glitch_55");

        // Back-to-back frames
        send_frame(8'h12, 1'b0, uart_pkg::EVEN, 1'b0, 1'b1, 8, -1, -1);
        send_frame(8'h34, 1'b0, uart_pkg::EVEN, 1'b0, 1'b1, 8, -1, -1);
        idle(4);
        verify("b2b_12_34");

        // Reset in the middle of a frame
        send_frame(8'hC3, 1'b1, uart_pkg::EVEN, 1'b0, 1'b1, 16, -1, 70);
        RST = 1'b0;
        #1;
        chk_outputs_zero("mid_reset_now");
        RX_IN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk_outputs_zero("mid_reset_hold");
        exp_pdata = '0;
        RST = 1'b1;
        idle(3);
        verify("mid_reset");
        send_frame(8'h96, 1'b1, uart_pkg::ODD, 1'b0, 1'b1, 16, -1, -1);
        idle(4);
        verify("after_reset_96");

        // Randomized frames
        for (int i = 0; i < 16; i++) begin
            d    = DW'($urandom);
            pen  = 1'($urandom);
            ptyp = 1'($urandom);
            flip = ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 4) != 0);
            p    = 8 << $urandom_range(0, 2);
            g    = ($urandom_range(0, 1) == 1) ? ($urandom_range(1, DW) * p + p / 2 - 1 + $urandom_range(0, 2)) : -1;
            send_frame(d, pen, ptyp, flip, stop, p, g, -1);
            idle($urandom_range(1, 5));
            verify("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
